sidewalk_matrix_seq: RTL and testbench



---
 rtl/sidewalk_matrix_seq.sv | 154 +++++++++++++++
 tb/tb_sidewalk_matrix_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sidewalk_matrix_seq.sv
// Column-scanned pedestrian light matrix driver: STOP -> WALK -> FLASH -> STOP
// phase sequencer feeding an external glyph ROM, with registered row output.
module sidewalk_matrix_seq #(
    parameter int COLS             = 16,
    parameter int ROWS             = 16,
    parameter int SCAN_DIV         = 64,
    parameter int SWEEPS_PER_FRAME = 16,
    parameter int N_WALK_FRAMES    = 18,
    parameter int STOP_FRAMES      = 32,
    parameter int WALK_FRAMES      = 64,
    parameter int FLASH_FRAMES     = 16,
    parameter int AUTO_MODE        = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ped_req,
    input  logic                               force_stop,
    input  logic [ROWS-1:0]                    row_data,
    output logic [$clog2(N_WALK_FRAMES+1)-1:0] rom_frame,
    output logic [$clog2(COLS)-1:0]            rom_col,
    output logic [$clog2(COLS)-1:0]            cols,
    output logic [ROWS-1:0]                    rows,
    output logic                               walk,
    output logic                               flashing,
    output logic                               frame_tick
);
    localparam int CW   = $clog2(COLS);
    localparam int FW   = $clog2(N_WALK_FRAMES+1);
    localparam int SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int YW   = (SWEEPS_PER_FRAME > 1) ? $clog2(SWEEPS_PER_FRAME) : 1;
    localparam int PM1  = (STOP_FRAMES > WALK_FRAMES) ? STOP_FRAMES : WALK_FRAMES;
    localparam int PMAX = (PM1 > FLASH_FRAMES) ? PM1 : FLASH_FRAMES;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV-1);
    localparam logic [YW-1:0] SWEEP_LAST = YW'(SWEEPS_PER_FRAME-1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS-1);
    localparam logic [FW-1:0] ANIM_LAST  = FW'(N_WALK_FRAMES-1);
    localparam logic [FW-1:0] STOP_GLYPH = FW'(N_WALK_FRAMES);
    localparam logic [PW-1:0] STOP_LAST  = PW'(STOP_FRAMES-1);
    localparam logic [PW-1:0] WALK_LAST  = PW'(WALK_FRAMES-1);
    localparam logic [PW-1:0] FLASH_LAST = PW'(FLASH_FRAMES-1);

    typedef enum logic [1:0] {ST_STOP, ST_WALK, ST_FLASH} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   phase_cnt, phase_nxt;
    logic [FW-1:0]   anim_idx, anim_nxt, anim_inc;
    logic [SW-1:0]   scan_cnt;
    logic [YW-1:0]   sweep_cnt;
    logic            req_q, enter_walk, walk_d, flash_d;
    logic            col_tick, sweep_tick, frame_ev, blank;

    assign col_tick   = (scan_cnt == SCAN_LAST);
    assign sweep_tick = col_tick && (rom_col == COL_LAST);
    assign frame_ev   = sweep_tick && (sweep_cnt == SWEEP_LAST);
    assign anim_inc   = (anim_idx == ANIM_LAST) ? '0 : anim_idx + 1'b1;
    assign blank      = flashing & phase_cnt[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_STOP;
            phase_cnt <= '0;
            anim_idx  <= '0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            anim_idx  <= anim_nxt;
        end
    end

    // force_stop overrides everything; otherwise the phase only moves on frame boundaries.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase_cnt;
        anim_nxt   = anim_idx;
        enter_walk = 1'b0;
        if (force_stop) begin
            state_nxt = ST_STOP;
            phase_nxt = '0;
            anim_nxt  = '0;
        end else if (frame_ev) begin
            case (state)
                ST_STOP: begin
                    if (phase_cnt >= STOP_LAST && (AUTO_MODE != 0 || req_q)) begin
                        state_nxt  = ST_WALK;
                        phase_nxt  = '0;
                        anim_nxt   = '0;
                        enter_walk = 1'b1;
                    end else if (phase_cnt < STOP_LAST) begin
                        phase_nxt = phase_cnt + 1'b1;
                    end
                end
                ST_WALK: begin
                    anim_nxt = anim_inc;
                    if (phase_cnt == WALK_LAST) begin
                        state_nxt = ST_FLASH;
                        phase_nxt = '0;
                    end else begin
                        phase_nxt = phase_cnt + 1'b1;
                    end
                end
                ST_FLASH: begin
                    anim_nxt = anim_inc;
                    if (phase_cnt == FLASH_LAST) begin
                        state_nxt = ST_STOP;
                        phase_nxt = '0;
                    end else begin
                        phase_nxt = phase_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_STOP;
                    phase_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        walk_d  = (state == ST_WALK) || (state == ST_FLASH);
        flash_d = (state == ST_FLASH);
    end

    // The frame address is taken from the next state so a new frame's glyph starts at column 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt   <= '0;
            sweep_cnt  <= '0;
            rom_col    <= '0;
            rom_frame  <= STOP_GLYPH;
            cols       <= '0;
            rows       <= '0;
            walk       <= 1'b0;
            flashing   <= 1'b0;
            frame_tick <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            scan_cnt <= col_tick ? '0 : scan_cnt + 1'b1;
            if (col_tick) begin
                rom_col   <= (rom_col == COL_LAST) ? '0 : rom_col + 1'b1;
                rom_frame <= (state_nxt == ST_STOP) ? STOP_GLYPH : anim_nxt;
            end
            if (sweep_tick)
                sweep_cnt <= (sweep_cnt == SWEEP_LAST) ? '0 : sweep_cnt + 1'b1;
            cols       <= rom_col;
            rows       <= blank ? '0 : row_data;
            walk       <= walk_d;
            flashing   <= flash_d;
            frame_tick <= frame_ev;
            req_q      <= ped_req | (req_q & ~enter_walk);
        end
    end
endmodule

// File: tb/tb_sidewalk_matrix_seq.sv
// Directed bench for sidewalk_matrix_seq with a per-clock behavioural model and literal pins.
module tb_sidewalk_matrix_seq;
    localparam int COLS = 4, ROWS = 8, SD = 2, SWP = 1, NWF = 3;
    localparam int STOPF = 2, WALKF = 4, FLASHF = 2, AUTO = 0;
    localparam int FCLK = SD * COLS * SWP;

    logic       clk = 1'b0;
    logic       rst, ped_req, force_stop;
    logic [7:0] row_data;
    logic [1:0] rom_frame, rom_col, cols;
    logic [7:0] rows;
    logic       walk, flashing, frame_tick;

    sidewalk_matrix_seq #(
        .COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SD), .SWEEPS_PER_FRAME(SWP),
        .N_WALK_FRAMES(NWF), .STOP_FRAMES(STOPF), .WALK_FRAMES(WALKF),
        .FLASH_FRAMES(FLASHF), .AUTO_MODE(AUTO)
    ) dut (
        .clk(clk), .rst(rst), .ped_req(ped_req), .force_stop(force_stop),
        .row_data(row_data), .rom_frame(rom_frame), .rom_col(rom_col),
        .cols(cols), .rows(rows), .walk(walk), .flashing(flashing),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Glyph ROM: never all-zero, so a dark column is always distinguishable.
    function automatic logic [7:0] rom(input int f, input int c);
        logic [1:0] ff, cc;
        ff = f[1:0];
        cc = c[1:0];
        return {2'b10, ff, cc, 2'b01};
    endfunction

    assign row_data = rom(int'(rom_frame), int'(rom_col));

    int errors = 0, checks = 0;
    // model: 0=STOP 1=WALK 2=FLASH
    int mk, mst, mph, man, mreq, ecol, efr, ecols, erows, ewalk, eflash, eft;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit colt, fev, pblank, entered;
        int pst;
        if (rst) begin
            mk = 0; mst = 0; mph = 0; man = 0; mreq = 0;
            ecol = 0; efr = NWF; ecols = 0; erows = 0;
            ewalk = 0; eflash = 0; eft = 0;
        end else begin
            colt    = (mk % SD) == SD - 1;
            fev     = (mk % FCLK) == FCLK - 1;
            pst     = mst;
            pblank  = (mst == 2) && (mph % 2 == 1);
            ecols   = ecol;
            erows   = pblank ? 0 : int'(rom(efr, ecol));
            entered = 0;
            if (force_stop) begin
                mst = 0; mph = 0; man = 0;
            end else if (fev) begin
                if (mst == 0) begin
                    if (mph >= STOPF - 1 && (AUTO != 0 || mreq != 0)) begin
                        mst = 1; mph = 0; man = 0; entered = 1;
                    end else if (mph < STOPF - 1) mph++;
                end else begin
                    man = (man + 1) % NWF;
                    if (mst == 1 && mph == WALKF - 1) begin mst = 2; mph = 0; end
                    else if (mst == 2 && mph == FLASHF - 1) begin mst = 0; mph = 0; end
                    else mph++;
                end
            end
            mreq = (ped_req || (mreq != 0 && !entered)) ? 1 : 0;
            if (colt) begin
                ecol = ((mk + 1) / SD) % COLS;
                efr  = (mst == 0) ? NWF : man;
            end
            eft    = fev;
            ewalk  = (pst != 0);
            eflash = (pst == 2);
            mk++;
        end
    endtask

    // One clock: model follows the edge, then every output is compared 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("rom_col", rom_col, ecol);
        chk("rom_frame", rom_frame, efr);
        chk("cols", cols, ecols);
        chk("rows", rows, erows);
        chk("walk", walk, ewalk);
        chk("flashing", flashing, eflash);
        chk("frame_tick", frame_tick, eft);
        chk("req_latch", dut.req_q, mreq);
    endtask

    task automatic wait_walk(input logic val, input int bound, output int n);
        n = 0;
        while (walk != val && n < bound) begin step(); n++; end
        if (walk != val) chk("wait_walk_timeout", n, -1);
    endtask

    initial begin
        int n, wonly, fl, zeros, chg, idx;
        logic [1:0] last_col;
        int col_seq [8]   = '{0, 1, 1, 2, 2, 3, 3, 0};
        int cols_seq [8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
        int frame_seq [6] = '{1, 2, 0, 1, 2, 3};

        rst = 1'b1; ped_req = 1'b0; force_stop = 1'b0;
        repeat (3) step();
        chk("rst_cols", cols, 0);
        chk("rst_rows", rows, 0);
        chk("rst_rom_frame", rom_frame, 3);
        chk("rst_rom_col", rom_col, 0);
        chk("rst_walk", walk, 0);
        chk("rst_frame_tick", frame_tick, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            step();
            chk("scan_rom_col", rom_col, col_seq[i]);
            chk("scan_cols", cols, cols_seq[i]);
        end
        repeat (192) step();
        chk("idle_walk", walk, 0);
        chk("idle_rom_frame", rom_frame, 3);

        // Full cycle from a one-clock request.
        ped_req = 1'b1; step(); ped_req = 1'b0;
        wait_walk(1'b1, 100, n);
        chk("walk_entry_frame", rom_frame, 0);
        chk("latch_cleared", dut.req_q, 0);
        wonly = 0; fl = 0; zeros = 0; idx = 0; n = 0;
        while (walk && n < 200) begin
            if (!flashing) wonly++;
            if (flashing) fl++;
            if (rows == 8'd0) zeros++;
            if (frame_tick) begin
                if (idx < 6) chk("frame_seq", rom_frame, frame_seq[idx]);
                idx++;
            end
            step(); n++;
        end
        chk("walk_ended", walk, 0);
        chk("walk_clocks", wonly, 4 * FCLK);
        chk("flash_clocks", fl, 2 * FCLK);
        chk("dark_rows", zeros, FCLK);
        chk("frame_tick_count", idx, 6);
        chk("stop_glyph", rom_frame, 3);

        // force_stop mid-WALK on a clock that is not a column boundary.
        ped_req = 1'b1; step(); ped_req = 1'b0;
        wait_walk(1'b1, 100, n);
        repeat (10) step();
        n = 0;
        while (mk % SD != 0 && n < 4) begin step(); n++; end
        force_stop = 1'b1; step(); force_stop = 1'b0;
        step();
        chk("force_walk", walk, 0);
        chk("force_glyph", rom_frame, 3);
        chg = 0; last_col = rom_col;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rom_col != last_col) chg++;
            last_col = rom_col;
        end
        chk("force_col_period", chg, 4);
        repeat (40) step();
        chk("force_stays_stop", walk, 0);

        // Request held across WALK entry stays latched for the next STOP.
        ped_req = 1'b1;
        wait_walk(1'b1, 100, n);
        repeat (2) step();
        chk("latch_kept", dut.req_q, 1);
        ped_req = 1'b0;
        wait_walk(1'b0, 200, n);
        n = 0;
        while (!walk && n < 100) begin step(); n++; end
        chk("stop_after_latch", n, STOPF * FCLK);
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
